// File: rtl/clock_pkg.sv
// Shared constants for the clock-setting front end: button indices and
// the per-channel auto-repeat state encoding.
package clock_pkg;

  localparam int NUM_BTNS = 5;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

endpackage

// File: rtl/button_conditioner_if.sv
// Bundle of raw button pins and the conditioned event outputs.
// slave = the conditioner, master = whoever drives the pins and consumes events.
interface button_conditioner_if #(
  parameter int NUM_BTNS = clock_pkg::NUM_BTNS
);
  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_level;
  logic [NUM_BTNS-1:0] btn_press;
  logic [NUM_BTNS-1:0] btn_release;
  logic [NUM_BTNS-1:0] btn_repeat;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_repeat
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_repeat
  );
endinterface

// File: rtl/button_channel.sv
// One button: two-flop synchronizer, stable-count debouncer and an
// IDLE/DELAY/REPEAT auto-repeat machine. Every output is a register.
module button_channel
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 25_000_000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TM_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TM_W   = $clog2(TM_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] DLY_LAST = TM_W'(REPEAT_DELAY - 1);
  localparam logic [TM_W-1:0] PER_LAST = TM_W'(REPEAT_PERIOD - 1);

  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] db_cnt;
  logic            differ;
  logic            flip;
  logic            press_evt;
  logic            release_evt;

  rep_state_t      state_q;
  rep_state_t      state_d;
  logic [TM_W-1:0] timer_q;
  logic [TM_W-1:0] timer_d;
  logic            repeat_d;

  // The level flips on the cycle the disagreement has lasted DEBOUNCE_CYCLES
  // cycles; press/release are derived from that same flip.
  assign differ      = (sync2 != btn_level);
  assign flip        = differ && (db_cnt == DB_LAST);
  assign press_evt   = flip && sync2;
  assign release_evt = flip && !sync2;

  // Synchronize the pin, count disagreement cycles, register level and edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      db_cnt      <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      sync1       <= raw;
      sync2       <= sync1;
      btn_press   <= press_evt;
      btn_release <= release_evt;
      if (flip) begin
        btn_level <= sync2;
        db_cnt    <= '0;
      end else if (!differ) begin
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Repeat state, hold timer and registered repeat pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      btn_repeat <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      btn_repeat <= repeat_d;
    end
  end

  // Next-state logic; the timer restarts on every state entry and on each repeat tick.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + TM_W'(1);
    repeat_d = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (press_evt) begin
          repeat_d = 1'b1;
          if (REPEAT_EN) state_d = DELAY;
        end
      end
      DELAY: begin
        if (release_evt) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == DLY_LAST) begin
          state_d  = REPEAT;
          timer_d  = '0;
          repeat_d = 1'b1;
        end
      end
      REPEAT: begin
        if (release_evt) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == PER_LAST) begin
          timer_d  = '0;
          repeat_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the pushbuttons into debounced levels and single-cycle
// press / release / auto-repeat events, one independent channel per button.
module button_conditioner #(
  parameter int                  NUM_BTNS        = clock_pkg::NUM_BTNS,
  parameter int                  DEBOUNCE_CYCLES = 1_000_000,
  parameter int                  REPEAT_DELAY    = 50_000_000,
  parameter int                  REPEAT_PERIOD   = 25_000_000,
  parameter logic [NUM_BTNS-1:0] REPEAT_MASK     = 5'b10010
) (
  input logic                 clk,
  input logic                 rst,
  button_conditioner_if.slave btn
);

  logic [NUM_BTNS-1:0] level_v;
  logic [NUM_BTNS-1:0] press_v;
  logic [NUM_BTNS-1:0] release_v;
  logic [NUM_BTNS-1:0] repeat_v;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .raw         (btn.btn_raw[i]),
      .btn_level   (level_v[i]),
      .btn_press   (press_v[i]),
      .btn_release (release_v[i]),
      .btn_repeat  (repeat_v[i])
    );
  end

  assign btn.btn_level   = level_v;
  assign btn.btn_press   = press_v;
  assign btn.btn_release = release_v;
  assign btn.btn_repeat  = repeat_v;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with short debounce/repeat timings.
// Stimulus queues the expected pulse events; a monitor matches every pulse.
module tb_button_conditioner;

  typedef struct {
    int         cyc;
    logic [4:0] p;
    logic [4:0] r;
    logic [4:0] q;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  sb[$];

  button_conditioner_if #(.NUM_BTNS(5)) bif ();

  button_conditioner #(
    .NUM_BTNS        (5),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (5),
    .REPEAT_MASK     (5'b10010)
  ) dut (
    .clk (clk),
    .rst (rst),
    .btn (bif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [4:0] p, input logic [4:0] r, input logic [4:0] q);
    ev_t e;
    e.cyc = c;
    e.p   = p;
    e.r   = r;
    e.q   = q;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every pulse on any channel must match the next queued event.
  always @(negedge clk) begin
    ev_t e;
    while (sb.size() != 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_event cyc=%0d got=none want press=%b release=%b repeat=%b",
               e.cyc, e.p, e.r, e.q);
    end
    if ((bif.btn_press | bif.btn_release | bif.btn_repeat) != 5'b0) begin
      checks++;
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        if (bif.btn_press !== e.p || bif.btn_release !== e.r || bif.btn_repeat !== e.q) begin
          errors++;
          $display("FAIL event cyc=%0d got press=%b release=%b repeat=%b want press=%b release=%b repeat=%b",
                   cyc, bif.btn_press, bif.btn_release, bif.btn_repeat, e.p, e.r, e.q);
        end
      end else begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got press=%b release=%b repeat=%b want none",
                 cyc, bif.btn_press, bif.btn_release, bif.btn_repeat);
      end
    end
  end

  initial begin
    int t0;
    bif.btn_raw = 5'b0;
    rst = 1'b1;
    step(3);
    chk("reset_outputs", {12'b0, bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_repeat}, 32'd0);
    rst = 1'b0;
    step(2);

    // U: clean press, held 40 cycles with auto-repeat, then release
    t0 = cyc;
    push(t0 + 6,  5'b00010, 5'b00000, 5'b00010);
    push(t0 + 16, 5'b00000, 5'b00000, 5'b00010);
    push(t0 + 21, 5'b00000, 5'b00000, 5'b00010);
    push(t0 + 26, 5'b00000, 5'b00000, 5'b00010);
    push(t0 + 31, 5'b00000, 5'b00000, 5'b00010);
    push(t0 + 36, 5'b00000, 5'b00000, 5'b00010);
    push(t0 + 41, 5'b00000, 5'b00000, 5'b00010);
    push(t0 + 46, 5'b00000, 5'b00010, 5'b00000);
    bif.btn_raw = 5'b00010;
    step(5);
    chk("u_level_before", 32'(bif.btn_level), 32'h00);
    step(1);
    chk("u_level_after", 32'(bif.btn_level), 32'h02);
    step(34);
    bif.btn_raw = 5'b00000;
    step(5);
    chk("u_level_held", 32'(bif.btn_level), 32'h02);
    step(1);
    chk("u_level_released", 32'(bif.btn_level), 32'h00);
    step(14);

    // C: 3-cycle bounce for 30 cycles, then held 40 cycles (no auto-repeat)
    t0 = cyc;
    push(t0 + 36, 5'b00001, 5'b00000, 5'b00001);
    push(t0 + 76, 5'b00000, 5'b00001, 5'b00000);
    for (int k = 0; k < 10; k++) begin
      bif.btn_raw = (k % 2 == 0) ? 5'b00001 : 5'b00000;
      step(3);
    end
    chk("c_bounce_level", 32'(bif.btn_level), 32'h00);
    bif.btn_raw = 5'b00001;
    step(36);
    chk("c_level_held", 32'(bif.btn_level), 32'h01);
    step(4);
    bif.btn_raw = 5'b00000;
    step(6);
    chk("c_level_released", 32'(bif.btn_level), 32'h00);
    step(10);

    // U and D together, L three cycles later
    t0 = cyc;
    push(t0 + 6,  5'b10010, 5'b00000, 5'b10010);
    push(t0 + 9,  5'b00100, 5'b00000, 5'b00100);
    push(t0 + 16, 5'b00000, 5'b00000, 5'b10010);
    push(t0 + 21, 5'b00000, 5'b00000, 5'b10010);
    push(t0 + 26, 5'b00000, 5'b00000, 5'b10010);
    push(t0 + 31, 5'b00000, 5'b00000, 5'b10010);
    push(t0 + 34, 5'b00000, 5'b10110, 5'b00000);
    bif.btn_raw = 5'b10010;
    step(3);
    bif.btn_raw = 5'b10110;
    step(25);
    bif.btn_raw = 5'b00000;
    step(5);
    chk("multi_level_held", 32'(bif.btn_level), 32'h16);
    step(1);
    chk("multi_level_released", 32'(bif.btn_level), 32'h00);
    step(10);

    // U held, reset pulsed for 2 cycles mid-hold
    t0 = cyc;
    push(t0 + 6,  5'b00010, 5'b00000, 5'b00010);
    push(t0 + 19, 5'b00010, 5'b00000, 5'b00010);
    push(t0 + 29, 5'b00000, 5'b00000, 5'b00010);
    push(t0 + 34, 5'b00000, 5'b00000, 5'b00010);
    push(t0 + 39, 5'b00000, 5'b00000, 5'b00010);
    push(t0 + 42, 5'b00000, 5'b00010, 5'b00000);
    bif.btn_raw = 5'b00010;
    step(11);
    chk("rst_pre_level", 32'(bif.btn_level), 32'h02);
    rst = 1'b1;
    step(1);
    chk("rst_outputs_1", {12'b0, bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_repeat}, 32'd0);
    step(1);
    chk("rst_outputs_2", {12'b0, bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_repeat}, 32'd0);
    rst = 1'b0;
    step(5);
    chk("rst_level_latency", 32'(bif.btn_level), 32'h00);
    step(1);
    chk("rst_level_repress", 32'(bif.btn_level), 32'h02);
    step(17);
    bif.btn_raw = 5'b00000;
    step(6);
    chk("rst_level_released", 32'(bif.btn_level), 32'h00);
    step(10);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
